// File: rtl/avalon_arbiter.sv
// Two-requester round-robin arbiter bridging 16-bit word requests onto a
// 32-bit Avalon-MM master port, one transfer at a time (IDLE -> BUS -> DONE).
module avalon_arbiter #(
  parameter logic [15:0] MEM_END_WORD_ADDR = 16'h0080,
  parameter int unsigned BYTE_PER_WORD     = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        R0_req,
  input  logic        R1_req,
  input  logic        R0_W,
  input  logic        R1_W,
  input  logic [15:0] R0_ADDR,
  input  logic [15:0] R1_ADDR,
  input  logic [15:0] R0_DOUT,
  input  logic [15:0] R1_DOUT,
  output logic        R0_ack,
  output logic        R1_ack,
  output logic [15:0] R0_DIN,
  output logic [15:0] R1_DIN,
  output logic        grant,
  input  logic        avalon_wait_request,
  input  logic [31:0] avalon_readdata,
  output logic        avalon_read,
  output logic        avalon_write,
  output logic [31:0] avalon_address,
  output logic [31:0] avalon_writedata,
  output logic [3:0]  avalon_byteenable
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        w_q, w_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [15:0] din0_q, din0_d;
  logic [15:0] din1_q, din1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic        win_s;
  logic        win_w_s;

  // Low word addresses are scaled to byte addresses; the rest pass through.
  function automatic logic [15:0] byte_addr(input logic [15:0] a);
    logic [31:0] prod;
    prod = 32'(a) * 32'(BYTE_PER_WORD);
    if (a <= MEM_END_WORD_ADDR) begin
      byte_addr = prod[15:0];
    end else begin
      byte_addr = a;
    end
  endfunction

  // Winner selection: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    win_s   = 1'b0;
    win_w_s = R0_W;
    if (R0_req && R1_req) begin
      win_s = ~last_q;
    end else begin
      win_s = R1_req;
    end
    win_w_s = win_s ? R1_W : R0_W;
  end

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    addr_d  = addr_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    din0_d  = din0_q;
    din1_d  = din1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    be_d    = 4'b0000;
    case (state_q)
      IDLE: begin
        if (R0_req || R1_req) begin
          state_d = BUS;
          grant_d = win_s;
          last_d  = win_s;
          w_d     = win_w_s;
          addr_d  = byte_addr(win_s ? R1_ADDR : R0_ADDR);
          data_d  = win_s ? R1_DOUT : R0_DOUT;
          rd_d    = ~win_w_s;
          wr_d    = win_w_s;
          be_d    = 4'b0011;
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (avalon_wait_request) begin
          state_d = BUS;
          rd_d    = ~w_q;
          wr_d    = w_q;
          be_d    = 4'b0011;
        end else begin
          state_d = DONE;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          if (!w_q && grant_q) begin
            din1_d = avalon_readdata[15:0];
          end else if (!w_q) begin
            din0_d = avalon_readdata[15:0];
          end else begin
            din0_d = din0_q;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; last_q resets to 1 so R0 wins the first contention.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      w_q     <= 1'b0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      din0_q  <= 16'h0000;
      din1_q  <= 16'h0000;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      din0_q  <= din0_d;
      din1_q  <= din1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
    end
  end

  assign R0_ack            = ack0_q;
  assign R1_ack            = ack1_q;
  assign R0_DIN            = din0_q;
  assign R1_DIN            = din1_q;
  assign grant             = grant_q;
  assign avalon_read       = rd_q;
  assign avalon_write      = wr_q;
  assign avalon_byteenable = be_q;
  assign avalon_address    = {16'h0000, addr_q};
  assign avalon_writedata  = {16'h0000, data_q};

endmodule

// File: tb/tb_avalon_arbiter.sv
// Self-checking bench for avalon_arbiter: directed scenarios plus randomized
// transfers checked against a transaction-level round-robin model.
module tb_avalon_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        R0_req = 1'b0, R1_req = 1'b0, R0_W = 1'b0, R1_W = 1'b0;
  logic [15:0] R0_ADDR = 16'h0, R1_ADDR = 16'h0, R0_DOUT = 16'h0, R1_DOUT = 16'h0;
  logic        R0_ack, R1_ack, grant;
  logic [15:0] R0_DIN, R1_DIN;
  logic        avalon_wait_request = 1'b0;
  logic [31:0] avalon_readdata = 32'h0;
  logic        avalon_read, avalon_write;
  logic [31:0] avalon_address, avalon_writedata;
  logic [3:0]  avalon_byteenable;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_last;
  logic [15:0] exp_din [2];

  avalon_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .R0_req(R0_req), .R1_req(R1_req), .R0_W(R0_W), .R1_W(R1_W),
    .R0_ADDR(R0_ADDR), .R1_ADDR(R1_ADDR), .R0_DOUT(R0_DOUT), .R1_DOUT(R1_DOUT),
    .R0_ack(R0_ack), .R1_ack(R1_ack), .R0_DIN(R0_DIN), .R1_DIN(R1_DIN),
    .grant(grant), .avalon_wait_request(avalon_wait_request),
    .avalon_readdata(avalon_readdata), .avalon_read(avalon_read),
    .avalon_write(avalon_write), .avalon_address(avalon_address),
    .avalon_writedata(avalon_writedata), .avalon_byteenable(avalon_byteenable)
  );

  always #5 Clock = ~Clock;

  // Expected byte address from a word address (default parameters).
  function automatic logic [31:0] exp_addr(input logic [15:0] a);
    int unsigned v;
    v = a;
    if (v <= 128) v = (v * 4) % 65536;
    return v;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({avalon_read, avalon_write, avalon_byteenable, R0_ack, R1_ack, grant} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got rd=%b wr=%b be=%b ack=%b%b grant=%b want all 0",
               avalon_read, avalon_write, avalon_byteenable, R1_ack, R0_ack, grant);
    end
    n_checks++;
    if ({R0_DIN, R1_DIN} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_din got %h/%h want 0000/0000", R0_DIN, R1_DIN);
    end
    Reset      = 1'b0;
    exp_last   = 1'b1;
    exp_din[0] = 16'h0;
    exp_din[1] = 16'h0;
  endtask

  task automatic test_read_zero_wait();
    R0_req = 1'b1; R0_W = 1'b0; R0_ADDR = 16'h0010; R0_DOUT = 16'h7777;
    avalon_wait_request = 1'b0;
    tick();
    n_checks++;
    if ({avalon_read, avalon_write, avalon_byteenable, grant, R0_ack} !== 8'b1000_1100 ||
        avalon_address !== 32'h40) begin
      n_fail++;
      $display("FAIL read_bus got rd=%b wr=%b be=%b grant=%b ack0=%b addr=%h want 1 0 0011 0 0 00000040",
               avalon_read, avalon_write, avalon_byteenable, grant, R0_ack, avalon_address);
    end
    avalon_readdata = 32'hA5A5_1234;
    tick();
    n_checks++;
    if ({avalon_read, R0_ack, R1_ack} !== 3'b010 || R0_DIN !== 16'h1234) begin
      n_fail++;
      $display("FAIL read_done got rd=%b ack0=%b ack1=%b din0=%h want 0 1 0 1234",
               avalon_read, R0_ack, R1_ack, R0_DIN);
    end
    R0_req = 1'b0;
    tick();
    n_checks++;
    if ({R0_ack, R1_ack, avalon_read, avalon_byteenable} !== 7'b0) begin
      n_fail++;
      $display("FAIL read_ack_once got ack0=%b ack1=%b rd=%b be=%b want all 0",
               R0_ack, R1_ack, avalon_read, avalon_byteenable);
    end
    exp_last   = 1'b0;
    exp_din[0] = 16'h1234;
  endtask

  task automatic test_write_wait();
    R1_req = 1'b1; R1_W = 1'b1; R1_ADDR = 16'h0100; R1_DOUT = 16'hBEEF;
    avalon_wait_request = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({avalon_read, avalon_write, avalon_byteenable, grant, R0_ack, R1_ack} !== 9'b01_0011_100 ||
          avalon_address !== 32'h100 || avalon_writedata !== 32'h0000BEEF) begin
        n_fail++;
        $display("FAIL write_bus[%0d] got rd=%b wr=%b be=%b grant=%b ack=%b%b addr=%h wd=%h want 0 1 0011 1 00 00000100 0000beef",
                 i, avalon_read, avalon_write, avalon_byteenable, grant, R1_ack, R0_ack,
                 avalon_address, avalon_writedata);
      end
      if (i == 1) begin
        R1_ADDR = 16'h0005; R1_DOUT = 16'h1111; R1_W = 1'b0;
      end
      if (i == 2) R1_req = 1'b0;
      avalon_wait_request = (i < 3);
      avalon_readdata     = 32'hFFFF_DEAD;
      tick();
    end
    n_checks++;
    if ({R1_ack, R0_ack, avalon_write} !== 3'b100 || R1_DIN !== 16'h0 || R0_DIN !== 16'h1234) begin
      n_fail++;
      $display("FAIL write_done got ack1=%b ack0=%b wr=%b din1=%h din0=%h want 1 0 0 0000 1234",
               R1_ack, R0_ack, avalon_write, R1_DIN, R0_DIN);
    end
    tick();
    n_checks++;
    if ({R0_ack, R1_ack, avalon_write} !== 3'b0) begin
      n_fail++;
      $display("FAIL write_ack_once got ack0=%b ack1=%b wr=%b want 0 0 0", R0_ack, R1_ack, avalon_write);
    end
    R1_W = 1'b0;
    avalon_wait_request = 1'b0;
    exp_last = 1'b1;
  endtask

  task automatic test_boundary();
    logic [15:0] addrs [2];
    logic [31:0] want  [2];
    addrs[0] = 16'h0080; want[0] = 32'h200;
    addrs[1] = 16'h0081; want[1] = 32'h81;
    for (int i = 0; i < 2; i++) begin
      R0_req = 1'b1; R0_W = 1'b1; R0_ADDR = addrs[i]; R0_DOUT = 16'h00A0 + 16'(i);
      tick();
      n_checks++;
      if (avalon_address !== want[i] || avalon_write !== 1'b1) begin
        n_fail++;
        $display("FAIL boundary_addr[%h] got addr=%h wr=%b want %h 1", addrs[i], avalon_address, avalon_write, want[i]);
      end
      R0_req = 1'b0;
      tick();
      tick();
    end
    exp_last = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [15:0] rd;
    Reset = 1'b1;
    tick();
    Reset = 1'b0; exp_last = 1'b1; exp_din[0] = 16'h0; exp_din[1] = 16'h0;
    R0_req = 1'b1; R1_req = 1'b1; R0_W = 1'b0; R1_W = 1'b0;
    R0_ADDR = 16'h0001; R1_ADDR = 16'h0002;
    avalon_wait_request = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_checks++;
      if (grant !== 1'(t % 2) || avalon_read !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant[%0d] got grant=%b rd=%b want %0d 1", t, grant, avalon_read, t % 2);
      end
      rd = 16'($urandom);
      avalon_readdata = {16'($urandom), rd};
      tick();
      exp_din[t % 2] = rd;
      n_checks++;
      if ({R1_ack, R0_ack} !== ((t % 2) ? 2'b10 : 2'b01) || R0_DIN !== exp_din[0] || R1_DIN !== exp_din[1]) begin
        n_fail++;
        $display("FAIL rr_done[%0d] got ack=%b%b din=%h/%h want slot %0d din=%h/%h",
                 t, R1_ack, R0_ack, R0_DIN, R1_DIN, t % 2, exp_din[0], exp_din[1]);
      end
      tick();
      n_checks++;
      if ({R1_ack, R0_ack, avalon_read} !== 3'b0) begin
        n_fail++;
        $display("FAIL rr_idle[%0d] got ack=%b%b rd=%b want 00 0", t, R1_ack, R0_ack, avalon_read);
      end
    end
    R0_req = 1'b0; R1_req = 1'b0;
    tick();
    exp_last = 1'b1;
  endtask

  task automatic test_reset_mid_bus();
    R1_req = 1'b1; R1_W = 1'b1; R1_ADDR = 16'h0300; R1_DOUT = 16'h5555;
    avalon_wait_request = 1'b1;
    tick();
    n_checks++;
    if (avalon_write !== 1'b1 || grant !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_bus_pre got wr=%b grant=%b want 1 1", avalon_write, grant);
    end
    Reset = 1'b1;
    tick();
    n_checks++;
    if ({avalon_read, avalon_write, avalon_byteenable, R0_ack, R1_ack, grant} !== 9'b0 ||
        {R0_DIN, R1_DIN} !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_bus got rd=%b wr=%b be=%b ack=%b%b grant=%b din=%h/%h want all 0",
               avalon_read, avalon_write, avalon_byteenable, R1_ack, R0_ack, grant, R0_DIN, R1_DIN);
    end
    Reset = 1'b0; exp_din[0] = 16'h0; exp_din[1] = 16'h0;
    R0_req = 1'b1; R0_W = 1'b0; R0_ADDR = 16'h0004;
    avalon_wait_request = 1'b0;
    avalon_readdata = 32'h0000_C0DE;
    tick();
    n_checks++;
    if ({grant, avalon_read, avalon_write, R0_ack, R1_ack} !== 5'b01000 || avalon_address !== 32'h10) begin
      n_fail++;
      $display("FAIL rst_release got grant=%b rd=%b wr=%b ack=%b%b addr=%h want 0 1 0 00 00000010",
               grant, avalon_read, avalon_write, R1_ack, R0_ack, avalon_address);
    end
    tick();
    n_checks++;
    if ({R1_ack, R0_ack} !== 2'b01 || R0_DIN !== 16'hC0DE) begin
      n_fail++;
      $display("FAIL rst_release_done got ack=%b%b din0=%h want 01 c0de", R1_ack, R0_ack, R0_DIN);
    end
    R0_req = 1'b0; R1_req = 1'b0;
    tick();
    exp_last   = 1'b0;
    exp_din[0] = 16'hC0DE;
  endtask

  task automatic test_random();
    logic        r0, r1, win, w;
    logic [15:0] a, d, rd;
    int          waits;
    for (int n = 0; n < 40; n++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      R0_req = r0; R1_req = r1;
      R0_W = 1'($urandom); R1_W = 1'($urandom);
      R0_ADDR = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      R1_ADDR = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      R0_DOUT = 16'($urandom); R1_DOUT = 16'($urandom);
      win   = (r0 && r1) ? ~exp_last : r1;
      w     = win ? R1_W : R0_W;
      a     = win ? R1_ADDR : R0_ADDR;
      d     = win ? R1_DOUT : R0_DOUT;
      waits = $urandom_range(0, 3);
      rd    = 16'h0;
      tick();
      for (int k = 0; k <= waits; k++) begin
        n_checks++;
        if ({avalon_read, avalon_write, avalon_byteenable, grant, R0_ack, R1_ack} !== {~w, w, 4'b0011, win, 2'b00} ||
            avalon_address !== exp_addr(a) || avalon_writedata !== {16'h0, d}) begin
          n_fail++;
          $display("FAIL rand_bus[%0d.%0d] got rd=%b wr=%b be=%b grant=%b ack=%b%b addr=%h wd=%h want rd=%b wr=%b be=0011 grant=%b ack=00 addr=%h wd=%h",
                   n, k, avalon_read, avalon_write, avalon_byteenable, grant, R1_ack, R0_ack,
                   avalon_address, avalon_writedata, ~w, w, win, exp_addr(a), {16'h0, d});
        end
        R0_ADDR = 16'($urandom); R1_ADDR = 16'($urandom);
        R0_DOUT = 16'($urandom); R1_DOUT = 16'($urandom);
        R0_W = 1'($urandom); R1_W = 1'($urandom);
        avalon_wait_request = (k < waits);
        rd = 16'($urandom);
        avalon_readdata = {16'($urandom), rd};
        tick();
      end
      if (!w) exp_din[win] = rd;
      n_checks++;
      if ({R1_ack, R0_ack} !== (win ? 2'b10 : 2'b01) || {avalon_read, avalon_write, avalon_byteenable} !== 6'b0 ||
          R0_DIN !== exp_din[0] || R1_DIN !== exp_din[1]) begin
        n_fail++;
        $display("FAIL rand_done[%0d] got ack=%b%b rd=%b wr=%b be=%b din=%h/%h want winner %0d strobes 0 din=%h/%h",
                 n, R1_ack, R0_ack, avalon_read, avalon_write, avalon_byteenable, R0_DIN, R1_DIN,
                 win, exp_din[0], exp_din[1]);
      end
      R0_req = 1'b0; R1_req = 1'b0;
      avalon_wait_request = 1'b0;
      tick();
      n_checks++;
      if ({R1_ack, R0_ack, avalon_read, avalon_write, avalon_byteenable} !== 8'b0) begin
        n_fail++;
        $display("FAIL rand_idle[%0d] got ack=%b%b rd=%b wr=%b be=%b want all 0",
                 n, R1_ack, R0_ack, avalon_read, avalon_write, avalon_byteenable);
      end
      exp_last = win;
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_boundary();
    test_round_robin();
    test_reset_mid_bus();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_arbiter.md
AVALON_ARBITER -- requirements
Module: avalon_arbiter

Interface
REQ-001 SHALL have parameter MEM_END_WORD_ADDR, default 16'h80, meaning the last word address that is scaled to a byte address.
REQ-002 SHALL have parameter BYTE_PER_WORD, default 4, meaning the word-to-byte scale factor applied at or below MEM_END_WORD_ADDR.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports R0_req and R1_req, input, 1 bit each: requester n wants a transfer.
REQ-006 SHALL have ports R0_W and R1_W, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports R0_ADDR and R1_ADDR, input, 16 bits each: word address.
REQ-008 SHALL have ports R0_DOUT and R1_DOUT, input, 16 bits each: write data.
REQ-009 SHALL have ports R0_ack and R1_ack, output, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL have ports R0_DIN and R1_DIN, output, 16 bits each: registered read data.
REQ-011 SHALL have port grant, output, 1 bit: index of the requester owning the current or last transfer.
REQ-012 SHALL have port avalon_wait_request, input, 1 bit: slave stall.
REQ-013 SHALL have port avalon_readdata, input, 32 bits: slave read data.
REQ-014 SHALL have ports avalon_read and avalon_write, output, 1 bit each: Avalon master strobes.
REQ-015 SHALL have ports avalon_address and avalon_writedata, output, 32 bits each: Avalon address and write data.
REQ-016 SHALL have port avalon_byteenable, output, 4 bits: Avalon byte enables.

Function
REQ-017 SHALL implement FSM states IDLE, BUS and DONE.
REQ-018 In IDLE with any Rn_req=1, SHALL latch the winner's W, ADDR and DOUT, set grant, and enter BUS on the next edge.
REQ-019 In IDLE with both requests high, SHALL grant the requester not granted last (round-robin); a single requester always wins.
REQ-020 In BUS, SHALL hold avalon_read=~W_latched and avalon_write=W_latched with stable address, data and byteenable while avalon_wait_request=1.
REQ-021 When avalon_wait_request=0 in BUS, SHALL capture avalon_readdata[15:0] into the granted Rn_DIN (reads only) and enter DONE.
REQ-022 In DONE, SHALL assert the granted Rn_ack for exactly one cycle, then return to IDLE.
REQ-023 Outside BUS, avalon_read, avalon_write and avalon_byteenable SHALL be 0, 0 and 4'b0000.
REQ-024 In BUS, avalon_byteenable SHALL be 4'b0011.
REQ-025 Latency: request seen in IDLE at cycle N gives strobe at N+1; zero-wait slave gives ack at N+2 and IDLE at N+3.
REQ-026 Address: if latched ADDR <= MEM_END_WORD_ADDR, byte address = ADDR*BYTE_PER_WORD truncated to 16 bits; otherwise ADDR unchanged.
REQ-027 avalon_address SHALL be the 16-bit byte address zero-extended to 32 bits.
REQ-028 avalon_writedata SHALL be {16'b0, DOUT_latched}.
REQ-029 A requester SHALL hold Rn_req and its inputs until Rn_ack; inputs changing during BUS SHALL NOT affect the transfer.
REQ-030 Rn_req dropped during BUS SHALL NOT abort the transfer; ack is still issued.
REQ-031 Rn_DIN SHALL hold its value until that requester's next read completes; writes SHALL NOT alter Rn_DIN.
REQ-032 A request still high in DONE SHALL compete again in the next IDLE under round-robin.

Reset
REQ-033 Reset=1 SHALL force state IDLE, all strobes and acks to 0, byteenable to 0, R0_DIN and R1_DIN to 0, grant to 0, and the round-robin pointer so that R0 wins the first contention.
REQ-034 Reset asserted in BUS or DONE SHALL drop the strobes on the next edge with no ack issued.

Verification
REQ-035 R0 read, ADDR=16'h0010, wait_request=0 -> avalon_address=32'h40, avalon_read=1 for 1 cycle, R0_DIN=readdata[15:0], R0_ack pulse at N+2.
REQ-036 R1 write, ADDR=16'h0100, DOUT=16'hBEEF, wait_request high 3 cycles -> avalon_address=32'h100, writedata=32'h0000BEEF held 4 cycles, then one R1_ack.
REQ-037 Boundary ADDR=16'h0080 -> address 32'h200; ADDR=16'h0081 -> 32'h81.
REQ-038 Both request continuously after reset -> grants alternate R0, R1, R0, R1; each ack arrives once per transfer.
REQ-039 Reset pulsed mid-BUS with wait_request=1 -> strobes 0 next cycle, no ack, FSM in IDLE, R0 granted first after release.
